// File: rtl/sprite_addr_pipeline_if.sv
// ---------------------------------------------------------------------------
// sprite_addr_pipeline_if
//
// Purpose: groups the descriptor-write bus, the streamed pixel input and the
// resolved address outputs of sprite_addr_pipeline into one bundle.
//
// Signals:
//   frame_sync        vertical-blank pulse, commits the descriptor table
//   desc_we/desc_idx  descriptor write strobe and target slot
//   desc_en/desc_flip slot enable and horizontal mirror flag
//   desc_x/desc_y     sprite centre on screen
//   desc_hx/desc_hy   half-width / half-height
//   desc_sx/desc_sy   sprite-sheet top-left of the frame
//   pix_valid         drawX/drawY qualifier
//   drawX/drawY       pixel being rendered
//   out_valid         output qualifier
//   sprite_hit        some enabled sprite covers the pixel
//   sprite_id         winning slot (0 on no hit)
//   SPRITE_ADDR       sprite-sheet SRAM address (0 on no hit)
//   background_ADDR   background frame SRAM address
//
// Modports: master drives descriptors/pixels (pixel counter side),
//           slave is the pipeline itself.
// ---------------------------------------------------------------------------
interface sprite_addr_pipeline_if #(
    parameter int NUM_SPR = 8,
    parameter int COORD_W = 10,
    parameter int ADDR_W  = 20
);
    localparam int IDX_W = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;

    logic               frame_sync;
    logic               desc_we;
    logic [IDX_W-1:0]   desc_idx;
    logic               desc_en;
    logic               desc_flip;
    logic [COORD_W-1:0] desc_x;
    logic [COORD_W-1:0] desc_y;
    logic [6:0]         desc_hx;
    logic [6:0]         desc_hy;
    logic [COORD_W-1:0] desc_sx;
    logic [COORD_W-1:0] desc_sy;
    logic               pix_valid;
    logic [COORD_W-1:0] drawX;
    logic [COORD_W-1:0] drawY;
    logic               out_valid;
    logic               sprite_hit;
    logic [IDX_W-1:0]   sprite_id;
    logic [ADDR_W-1:0]  SPRITE_ADDR;
    logic [ADDR_W-1:0]  background_ADDR;

    modport master (
        output frame_sync, desc_we, desc_idx, desc_en, desc_flip,
               desc_x, desc_y, desc_hx, desc_hy, desc_sx, desc_sy,
               pix_valid, drawX, drawY,
        input  out_valid, sprite_hit, sprite_id, SPRITE_ADDR, background_ADDR
    );

    modport slave (
        input  frame_sync, desc_we, desc_idx, desc_en, desc_flip,
               desc_x, desc_y, desc_hx, desc_hy, desc_sx, desc_sy,
               pix_valid, drawX, drawY,
        output out_valid, sprite_hit, sprite_id, SPRITE_ADDR, background_ADDR
    );
endinterface

// File: rtl/sprite_addr_pipeline.sv
// ---------------------------------------------------------------------------
// sprite_addr_pipeline
//
// Purpose: holds NUM_SPR sprite descriptors and, for every streamed screen
// pixel, resolves the highest-priority (lowest index) covering sprite and its
// sprite-sheet SRAM address, plus the background frame address. Three-stage
// pipeline, one pixel per cycle, no backpressure, latency 3 cycles:
//   S1  per-slot hit test and local coordinates (descriptor fields sampled)
//   S2  priority select of the lowest-index hit
//   S3  sheet address arithmetic, output registers
//
// Ports:
//   Clk      system clock
//   Reset_n  asynchronous active-low reset; clears table, valids, outputs
//   bus      sprite_addr_pipeline_if.slave (descriptor bus, pixels, outputs)
//
// Build option: define SPRITE_SHADOW_EN to route descriptor writes into a
// shadow table that is copied to the active table on frame_sync. Without it,
// writes hit the active table directly and frame_sync is ignored.
// ---------------------------------------------------------------------------
module sprite_addr_pipeline #(
    parameter int NUM_SPR = 8,
    parameter int COORD_W = 10,
    parameter int ADDR_W  = 20,
    parameter int SHEET_W = 512,
    parameter int BG_W    = 640
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    sprite_addr_pipeline_if.slave bus
);

    localparam int IDX_W = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
    localparam int CW1   = COORD_W + 1;
    // Local offsets span 0..2*127, so 8 bits are always enough.
    localparam int LW    = 8;

    typedef struct packed {
        logic               en;
        logic               flip;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [6:0]         hx;
        logic [6:0]         hy;
        logic [COORD_W-1:0] sx;
        logic [COORD_W-1:0] sy;
    } desc_t;

    desc_t act_tbl [NUM_SPR];
    desc_t wr_desc;

    always_comb begin
        wr_desc      = '0;
        wr_desc.en   = bus.desc_en;
        wr_desc.flip = bus.desc_flip;
        wr_desc.x    = bus.desc_x;
        wr_desc.y    = bus.desc_y;
        wr_desc.hx   = bus.desc_hx;
        wr_desc.hy   = bus.desc_hy;
        wr_desc.sx   = bus.desc_sx;
        wr_desc.sy   = bus.desc_sy;
    end

`ifdef SPRITE_SHADOW_EN
    // Writes collect in the shadow; frame_sync copies the whole shadow as it
    // stood before this edge, so a coincident write waits for the next commit.
    desc_t shd_tbl [NUM_SPR];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_SPR; i++) begin
                shd_tbl[i] <= '0;
                act_tbl[i] <= '0;
            end
        end else begin
            if (bus.desc_we)
                shd_tbl[bus.desc_idx] <= wr_desc;
            if (bus.frame_sync) begin
                for (int i = 0; i < NUM_SPR; i++)
                    act_tbl[i] <= shd_tbl[i];
            end
        end
    end
`else
    // Direct mode: writes land in the active table at the clock edge.
    logic unused_frame_sync;
    assign unused_frame_sync = bus.frame_sync;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_SPR; i++)
                act_tbl[i] <= '0;
        end else if (bus.desc_we) begin
            act_tbl[bus.desc_idx] <= wr_desc;
        end
    end
`endif

    // Offset of pixel p from the sprite's top-left edge (c - h), evaluated at
    // COORD_W+1 bits so sprites near coordinate 0 never wrap.
    function automatic logic [LW-1:0] local_off(
        input logic [COORD_W-1:0] p,
        input logic [COORD_W-1:0] c,
        input logic [6:0]         h
    );
        logic [CW1-1:0] d;
        d = {1'b0, p} + CW1'(h) - {1'b0, c};
        return d[LW-1:0];
    endfunction

    // ---------------------------------------------------------------- S1 ----
    // Per-slot coverage test with widened operands; the local coordinates are
    // only meaningful for slots that hit.
    logic [NUM_SPR-1:0] hit_c;
    logic [LW-1:0]      lx_c [NUM_SPR];
    logic [LW-1:0]      ly_c [NUM_SPR];
    logic [ADDR_W-1:0]  bg_c;

    always_comb begin
        hit_c = '0;
        for (int i = 0; i < NUM_SPR; i++) begin
            hit_c[i] = act_tbl[i].en
                     & (({1'b0, bus.drawX} + CW1'(act_tbl[i].hx)) >= {1'b0, act_tbl[i].x})
                     & ({1'b0, bus.drawX} <= ({1'b0, act_tbl[i].x} + CW1'(act_tbl[i].hx)))
                     & (({1'b0, bus.drawY} + CW1'(act_tbl[i].hy)) >= {1'b0, act_tbl[i].y})
                     & ({1'b0, bus.drawY} <= ({1'b0, act_tbl[i].y} + CW1'(act_tbl[i].hy)));
            lx_c[i]  = local_off(bus.drawX, act_tbl[i].x, act_tbl[i].hx);
            ly_c[i]  = local_off(bus.drawY, act_tbl[i].y, act_tbl[i].hy);
        end
        bg_c = ADDR_W'(bus.drawX) + ADDR_W'(bus.drawY) * ADDR_W'(BG_W);
    end

    logic               s1_valid;
    logic [NUM_SPR-1:0] s1_hit;
    logic [LW-1:0]      s1_lx   [NUM_SPR];
    logic [LW-1:0]      s1_ly   [NUM_SPR];
    logic [6:0]         s1_hx   [NUM_SPR];
    logic [COORD_W-1:0] s1_sx   [NUM_SPR];
    logic [COORD_W-1:0] s1_sy   [NUM_SPR];
    logic [NUM_SPR-1:0] s1_flip;
    logic [ADDR_W-1:0]  s1_bg;

    // S1 register: descriptor fields needed later are captured here so that a
    // table update never affects a pixel already in flight.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid <= 1'b0;
            s1_hit   <= '0;
            s1_flip  <= '0;
            s1_bg    <= '0;
            for (int i = 0; i < NUM_SPR; i++) begin
                s1_lx[i] <= '0;
                s1_ly[i] <= '0;
                s1_hx[i] <= '0;
                s1_sx[i] <= '0;
                s1_sy[i] <= '0;
            end
        end else begin
            s1_valid <= bus.pix_valid;
            s1_hit   <= hit_c;
            s1_bg    <= bg_c;
            for (int i = 0; i < NUM_SPR; i++) begin
                s1_lx[i]   <= lx_c[i];
                s1_ly[i]   <= ly_c[i];
                s1_hx[i]   <= act_tbl[i].hx;
                s1_sx[i]   <= act_tbl[i].sx;
                s1_sy[i]   <= act_tbl[i].sy;
                s1_flip[i] <= act_tbl[i].flip;
            end
        end
    end

    // ---------------------------------------------------------------- S2 ----
    // Priority select: scanning from the top index down lets the lowest hit
    // index overwrite everything above it. With no hit, all fields stay 0.
    logic               win_hit;
    logic [IDX_W-1:0]   win_id;
    logic [LW-1:0]      win_lx;
    logic [LW-1:0]      win_ly;
    logic [6:0]         win_hx;
    logic [COORD_W-1:0] win_sx;
    logic [COORD_W-1:0] win_sy;
    logic               win_flip;

    always_comb begin
        win_hit  = |s1_hit;
        win_id   = '0;
        win_lx   = '0;
        win_ly   = '0;
        win_hx   = '0;
        win_sx   = '0;
        win_sy   = '0;
        win_flip = 1'b0;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (s1_hit[i]) begin
                win_id   = IDX_W'(i);
                win_lx   = s1_lx[i];
                win_ly   = s1_ly[i];
                win_hx   = s1_hx[i];
                win_sx   = s1_sx[i];
                win_sy   = s1_sy[i];
                win_flip = s1_flip[i];
            end
        end
    end

    logic               s2_valid;
    logic               s2_hit;
    logic [IDX_W-1:0]   s2_id;
    logic [LW-1:0]      s2_lx;
    logic [LW-1:0]      s2_ly;
    logic [6:0]         s2_hx;
    logic [COORD_W-1:0] s2_sx;
    logic [COORD_W-1:0] s2_sy;
    logic               s2_flip;
    logic [ADDR_W-1:0]  s2_bg;

    // S2 register: winning slot's data plus the aligned background address.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s2_valid <= 1'b0;
            s2_hit   <= 1'b0;
            s2_id    <= '0;
            s2_lx    <= '0;
            s2_ly    <= '0;
            s2_hx    <= '0;
            s2_sx    <= '0;
            s2_sy    <= '0;
            s2_flip  <= 1'b0;
            s2_bg    <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_hit   <= win_hit;
            s2_id    <= win_id;
            s2_lx    <= win_lx;
            s2_ly    <= win_ly;
            s2_hx    <= win_hx;
            s2_sx    <= win_sx;
            s2_sy    <= win_sy;
            s2_flip  <= win_flip;
            s2_bg    <= s1_bg;
        end
    end

    // ---------------------------------------------------------------- S3 ----
    // Mirroring reflects the column about the sprite's width: ex = 2*hx - lx.
    logic [LW-1:0]     ex_c;
    logic [ADDR_W-1:0] addr_c;

    always_comb begin
        ex_c   = s2_flip ? ({s2_hx, 1'b0} - s2_lx) : s2_lx;
        addr_c = '0;
        if (s2_hit)
            addr_c = (ADDR_W'(s2_sx) + ADDR_W'(ex_c))
                   + (ADDR_W'(s2_sy) + ADDR_W'(s2_ly)) * ADDR_W'(SHEET_W);
    end

    // Output register: a bubble clears out_valid but the data outputs keep the
    // last valid pixel's values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bus.out_valid       <= 1'b0;
            bus.sprite_hit      <= 1'b0;
            bus.sprite_id       <= '0;
            bus.SPRITE_ADDR     <= '0;
            bus.background_ADDR <= '0;
        end else begin
            bus.out_valid <= s2_valid;
            if (s2_valid) begin
                bus.sprite_hit      <= s2_hit;
                bus.sprite_id       <= s2_id;
                bus.SPRITE_ADDR     <= addr_c;
                bus.background_ADDR <= s2_bg;
            end
        end
    end

endmodule

// File: tb/tb_sprite_addr_pipeline.sv
// ---------------------------------------------------------------------------
// tb_sprite_addr_pipeline
//
// Purpose: self-checking bench for sprite_addr_pipeline. Stimulus pushes the
// expected response of every issued pixel into a scoreboard queue; a separate
// monitor pops and compares whenever out_valid is seen. Expectations come from
// a plain-integer model of the descriptor table and the coverage rules.
// Works with and without SPRITE_SHADOW_EN defined.
// ---------------------------------------------------------------------------
module tb_sprite_addr_pipeline;

    localparam int NUM_SPR = 8;
    localparam int COORD_W = 10;
    localparam int ADDR_W  = 20;
    localparam int SHEET_W = 512;
    localparam int BG_W    = 640;
    localparam int AMOD    = 1 << ADDR_W;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;

    always #5 Clk = ~Clk;

    sprite_addr_pipeline_if #(.NUM_SPR(NUM_SPR), .COORD_W(COORD_W), .ADDR_W(ADDR_W)) bus ();

    sprite_addr_pipeline #(
        .NUM_SPR(NUM_SPR), .COORD_W(COORD_W), .ADDR_W(ADDR_W),
        .SHEET_W(SHEET_W), .BG_W(BG_W)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    typedef struct {
        bit en;
        bit flip;
        int x, y, hx, hy, sx, sy;
    } mdesc_t;

    typedef struct {
        bit hit;
        int id;
        int addr;
        int bg;
        int due;
    } exp_t;

    mdesc_t act [NUM_SPR];
    mdesc_t shd [NUM_SPR];
    exp_t   sb [$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic mdesc_t mk(bit en, bit flip, int x, int y, int hx, int hy, int sx, int sy);
        mdesc_t d;
        d.en = en; d.flip = flip; d.x = x; d.y = y;
        d.hx = hx; d.hy = hy; d.sx = sx; d.sy = sy;
        return d;
    endfunction

    // Reference: first enabled slot whose rectangle [c-h, c+h] contains the
    // pixel wins; addresses are plain integer arithmetic modulo 2^ADDR_W.
    function automatic exp_t model_pixel(int px, int py);
        exp_t e;
        e.hit = 0; e.id = 0; e.addr = 0; e.due = 0;
        e.bg  = (px + py * BG_W) % AMOD;
        for (int i = 0; i < NUM_SPR; i++) begin
            if (act[i].en && !e.hit) begin
                int left, top, lx, ly, ex;
                left = act[i].x - act[i].hx;
                top  = act[i].y - act[i].hy;
                if (px >= left && px <= act[i].x + act[i].hx &&
                    py >= top  && py <= act[i].y + act[i].hy) begin
                    lx = px - left;
                    ly = py - top;
                    ex = act[i].flip ? (2 * act[i].hx - lx) : lx;
                    e.hit  = 1;
                    e.id   = i;
                    e.addr = ((act[i].sx + ex) + (act[i].sy + ly) * SHEET_W) % AMOD;
                end
            end
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_SPR; i++) begin
            act[i] = mk(0, 0, 0, 0, 0, 0, 0, 0);
            shd[i] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic check_output(string name, int actual, int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // One cycle of stimulus, driven on the falling edge.
    task automatic apply_stimulus(bit we, int idx, mdesc_t d, bit fs, bit pv, int px, int py);
        exp_t e;
        @(negedge Clk);
        bus.desc_we    = we;
        bus.desc_idx   = 3'(idx);
        bus.desc_en    = d.en;
        bus.desc_flip  = d.flip;
        bus.desc_x     = COORD_W'(d.x);
        bus.desc_y     = COORD_W'(d.y);
        bus.desc_hx    = 7'(d.hx);
        bus.desc_hy    = 7'(d.hy);
        bus.desc_sx    = COORD_W'(d.sx);
        bus.desc_sy    = COORD_W'(d.sy);
        bus.frame_sync = fs;
        bus.pix_valid  = pv;
        bus.drawX      = COORD_W'(px);
        bus.drawY      = COORD_W'(py);
        if (pv) begin
            e = model_pixel(px, py);
            e.due = cyc + 3;
            sb.push_back(e);
        end
`ifdef SPRITE_SHADOW_EN
        if (fs) begin
            for (int i = 0; i < NUM_SPR; i++) act[i] = shd[i];
        end
        if (we) shd[idx] = d;
`else
        if (we) act[idx] = d;
`endif
    endtask

    mdesc_t zero_d;

    task automatic idle(int n);
        for (int k = 0; k < n; k++) apply_stimulus(0, 0, zero_d, 0, 0, 0, 0);
    endtask

    task automatic write_slot(int idx, mdesc_t d);
        apply_stimulus(1, idx, d, 0, 0, 0, 0);
    endtask

    task automatic commit();
        apply_stimulus(0, 0, zero_d, 1, 0, 0, 0);
    endtask

    task automatic pixel(int px, int py);
        apply_stimulus(0, 0, zero_d, 0, 1, px, py);
    endtask

    // Monitor: compares each presented output against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            #1;
            if (Reset_n && bus.out_valid) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_out_valid", int'(bus.out_valid), 0);
                end else begin
                    e = sb.pop_front();
                    check_output("latency", cyc, e.due);
                    check_output("sprite_hit", int'(bus.sprite_hit), int'(e.hit));
                    check_output("sprite_id", int'(bus.sprite_id), e.id);
                    check_output("SPRITE_ADDR", int'(bus.SPRITE_ADDR), e.addr);
                    check_output("background_ADDR", int'(bus.background_ADDR), e.bg);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d expectations pending", sb.size());
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        mdesc_t d;
        int s, px, py;
        zero_d = mk(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        bus.desc_we = 0; bus.desc_idx = '0; bus.desc_en = 0; bus.desc_flip = 0;
        bus.desc_x = '0; bus.desc_y = '0; bus.desc_hx = '0; bus.desc_hy = '0;
        bus.desc_sx = '0; bus.desc_sy = '0; bus.frame_sync = 0;
        bus.pix_valid = 0; bus.drawX = '0; bus.drawY = '0;

        repeat (2) @(negedge Clk);
        #1;
        check_output("reset_out_valid", int'(bus.out_valid), 0);
        check_output("reset_sprite_hit", int'(bus.sprite_hit), 0);
        check_output("reset_sprite_id", int'(bus.sprite_id), 0);
        check_output("reset_SPRITE_ADDR", int'(bus.SPRITE_ADDR), 0);
        check_output("reset_background_ADDR", int'(bus.background_ADDR), 0);
        @(negedge Clk);
        Reset_n = 1'b1;

        $display("[TB] empty table");
        pixel(100, 100);
        idle(4);

        $display("[TB] single sprite, plain and mirrored");
        write_slot(2, mk(1, 0, 100, 100, 26, 28, 5, 6));
        commit();
        pixel(74, 72);
        pixel(126, 128);
        pixel(127, 100);
        pixel(100, 71);
        write_slot(2, mk(1, 1, 100, 100, 26, 28, 5, 6));
        commit();
        pixel(74, 72);
        pixel(126, 128);

        $display("[TB] priority between overlapping slots");
        write_slot(1, mk(1, 0, 200, 200, 10, 10, 40, 50));
        write_slot(4, mk(1, 1, 205, 195, 20, 20, 300, 400));
        commit();
        pixel(200, 200);
        write_slot(1, mk(0, 0, 200, 200, 10, 10, 40, 50));
        commit();
        pixel(200, 200);

        $display("[TB] sprite at the left edge");
        write_slot(0, mk(1, 0, 5, 300, 10, 5, 0, 0));
        commit();
        pixel(1023, 300);
        pixel(0, 300);
        pixel(15, 305);
        pixel(16, 300);

        $display("[TB] write and commit ordering");
        write_slot(3, mk(1, 0, 400, 400, 5, 5, 100, 100));
        pixel(400, 400);
        apply_stimulus(1, 3, mk(1, 0, 400, 400, 5, 5, 200, 7), 1, 0, 0, 0);
        pixel(400, 400);
        commit();
        pixel(400, 400);
        write_slot(3, mk(1, 0, 400, 400, 5, 5, 9, 9));
        write_slot(3, mk(1, 1, 400, 400, 5, 5, 11, 13));
        commit();
        pixel(398, 401);
        idle(4);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 600; k++) begin
            bit we, fs, pv;
            we = ($urandom % 4) == 0;
            fs = ($urandom % 16) == 0;
            pv = ($urandom % 4) != 0;
            d = mk(($urandom % 4) != 0, $urandom % 2,
                   $urandom % 1024, $urandom % 1024,
                   $urandom % 128, $urandom % 128,
                   $urandom % 1024, $urandom % 1024);
            s  = $urandom % NUM_SPR;
            px = (act[s].x + $urandom_range(0, 300) - 150) & 1023;
            py = (act[s].y + $urandom_range(0, 300) - 150) & 1023;
            apply_stimulus(we, $urandom % NUM_SPR, d, fs, pv, px, py);
        end

        $display("[TB] reset mid-stream");
        for (int k = 0; k < 5; k++) pixel($urandom % 1024, $urandom % 1024);
        @(negedge Clk);
        Reset_n = 1'b0;
        bus.pix_valid = 0;
        bus.desc_we = 0;
        bus.frame_sync = 0;
        sb.delete();
        model_reset();
        #1;
        check_output("reset_async_out_valid", int'(bus.out_valid), 0);
        check_output("reset_async_SPRITE_ADDR", int'(bus.SPRITE_ADDR), 0);
        @(negedge Clk);
        #1;
        check_output("reset_held_out_valid", int'(bus.out_valid), 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            idle(1);
            #1;
            check_output("post_reset_out_valid", int'(bus.out_valid), 0);
        end
        pixel(100, 100);
        pixel(0, 0);
        idle(1);

        for (int k = 0; k < 10 && sb.size() > 0; k++) idle(1);
        check_output("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
